// File: rtl/seq_magnitude_comparator_if.sv
// rtl/seq_magnitude_comparator_if.sv - request/result bundle for the sequential magnitude comparator
//
// Purpose: groups the comparison request (start, a, b, signed_mode) and the
// registered status/result (busy, done, greater, equal, less) into one
// interface.
// Ports (signals):
//   start        master -> slave  request a comparison
//   a, b         master -> slave  operands, WIDTH bits
//   signed_mode  master -> slave  1 = two's-complement, 0 = unsigned
//   busy         slave -> master  comparison in progress
//   done         slave -> master  one-cycle result strobe
//   greater      slave -> master  A > B
//   equal        slave -> master  A == B
//   less         slave -> master  A < B
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             greater;
  logic             equal;
  logic             less;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, greater, equal, less
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, greater, equal, less
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - chunk-serial signed/unsigned magnitude comparator
//
// Purpose: compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk
// first. The first differing chunk decides the result.
// Option macro: SEQ_CMP_EARLY_EXIT_EN - when defined, the comparison ends on
// the edge that sees the first differing chunk; otherwise all N chunks are
// always scanned (fixed latency N = WIDTH/CHUNK).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   cmp  seq_magnitude_comparator_if.slave (start, a, b, signed_mode in;
//        busy, done, greater, equal, less out, all outputs registered)
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                      clk,
  input logic                      rst,
  seq_magnitude_comparator_if.slave cmp
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  // Operands are shifted left each cycle so the chunk under test is always
  // at the top; idx tracks which chunk that is.
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               gt_q;
  logic               lt_q;
  logic               busy_q;
  logic               done_q;
  logic               greater_q;
  logic               equal_q;
  logic               less_q;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic               chunk_gt;
  logic               chunk_lt;
  logic               next_gt;
  logic               next_lt;
  logic               last;
  logic [WIDTH-1:0]   msb_flip;

  always_comb begin
    a_chunk  = a_sh[WIDTH-1 -: CHUNK];
    b_chunk  = b_sh[WIDTH-1 -: CHUNK];
    chunk_gt = a_chunk > b_chunk;
    chunk_lt = a_chunk < b_chunk;
    // A decision already taken is sticky; only an undecided compare may
    // pick up the current chunk's verdict.
    next_gt  = gt_q | (~lt_q & chunk_gt);
    next_lt  = lt_q | (~gt_q & chunk_lt);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    last     = (idx == '0) | chunk_gt | chunk_lt;
`else
    last     = (idx == '0);
`endif
    // Flipping both MSBs maps two's-complement order onto unsigned order.
    msb_flip = {cmp.signed_mode, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp.start) begin
            a_sh   <= cmp.a ^ msb_flip;
            b_sh   <= cmp.b ^ msb_flip;
            idx    <= IDX_W'(N - 1);
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (last) begin
            greater_q <= next_gt;
            less_q    <= next_lt;
            equal_q   <= ~next_gt & ~next_lt;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            idx       <= '0;
            state     <= IDLE;
          end else begin
            gt_q <= next_gt;
            lt_q <= next_lt;
            a_sh <= a_sh << CHUNK;
            b_sh <= b_sh << CHUNK;
            idx  <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp.busy    = busy_q;
  assign cmp.done    = done_q;
  assign cmp.greater = greater_q;
  assign cmp.equal   = equal_q;
  assign cmp.less    = less_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .cmp (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [2:0]       gel;
    int               lat_early;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: ordering from plain integer arithmetic.
  function automatic logic [2:0] ref_gel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic sm);
    int va;
    int vb;
    va = sm ? int'($signed(a)) : int'(a);
    vb = sm ? int'($signed(b)) : int'(b);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency: N, or N-i for the highest differing chunk i with early exit.
  function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (((a >> (i * CHUNK)) & ((1 << CHUNK) - 1)) != ((b >> (i * CHUNK)) & ((1 << CHUNK) - 1)))
        return N - i;
    end
`endif
    return N;
  endfunction

  task automatic do_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tsm,
                        input string tag, output int lat, output logic [2:0] gel);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb_v;
    bus.signed_mode = tsm;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom);
    bus.signed_mode = 1'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 40);
    if (!bus.done) check({tag, "_timeout"}, 32'd0, 32'd1);
    gel = {bus.greater, bus.equal, bus.less};
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
  endtask

  vec_t        vecs[8];
  int          lat;
  logic [2:0]  gel;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic        rsm;
  int          dones;
  int          exp_lat;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 4};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1};
    vecs[3] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4};
    vecs[4] = '{16'h0001, 16'h0002, 1'b0, 3'b001, 4};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 3'b100, 1};
    vecs[6] = '{16'h1200, 16'h1300, 1'b0, 3'b001, 2};
    vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_early;
`else
      exp_lat = N;
`endif
      do_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, $sformatf("vec%0d", i), lat, gel);
      check($sformatf("vec%0d_result", i), 32'(gel), 32'(vecs[i].gel));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    // Start re-pulsed mid-compare is ignored: one done only, latency 4.
    @(negedge clk);
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    lat = 0;
    for (int e = 1; e <= 10; e++) begin
      if (e == 2) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (lat == 0) lat = e;
      end
    end
    check("ignore_start_dones", 32'(dones), 32'd1);
    check("ignore_start_latency", 32'(lat), 32'd4);
    check("ignore_start_result", {29'd0, bus.greater, bus.equal, bus.less}, 32'b001);

    // Reset at edge 2 of a compare.
    @(negedge clk);
    bus.a = 16'h1234;
    bus.b = 16'h1234;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_outputs", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midreset_no_done", 32'(dones), 32'd0);
    do_cmp(16'h8000, 16'h7FFF, 1'b0, "post_reset", lat, gel);
    check("post_reset_result", 32'(gel), 32'b100);
    check("post_reset_latency", 32'(lat), 32'(ref_lat(16'h8000, 16'h7FFF)));

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.a = 16'h8000;
    bus.b = 16'h7FFF;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 40);
    check("b2b_first_done", 32'(bus.done), 32'd1);
    check("b2b_first_result", {29'd0, bus.greater, bus.equal, bus.less}, 32'b100);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_second_busy", 32'(bus.busy), 32'd1);
    check("b2b_result_held", {29'd0, bus.greater, bus.equal, bus.less}, 32'b100);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 40);
    check("b2b_second_result", {29'd0, bus.greater, bus.equal, bus.less}, 32'b001);
    check("b2b_second_latency", 32'(lat), 32'(ref_lat(16'h0001, 16'h0002)));

    // Randomized against the arithmetic model; some operands share upper chunks.
    for (int i = 0; i < 150; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rsm = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = {ra[WIDTH-1:8], rb[7:0]};
        2: rb = {ra[WIDTH-1:4], rb[3:0]};
        default: ;
      endcase
      do_cmp(ra, rb, rsm, $sformatf("rnd%0d", i), lat, gel);
      check($sformatf("rnd%0d_result a=%h b=%h s=%0d", i, ra, rb, rsm), 32'(gel), 32'(ref_gel(ra, rb, rsm)));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_lat(ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
